// File: rtl/obstacle_pkg.sv
// +----------------------------------------------------------------------------+
// | obstacle_pkg: coordinate and vertex types shared by the obstacle culler.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package obstacle_pkg;

    localparam int COORD_BITS = 32;

    typedef logic signed [COORD_BITS-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bbox_accumulator.sv
// +----------------------------------------------------------------------------+
// | bbox_accumulator: running obstacle bounding box and screen overlap test.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bbox_accumulator
    import obstacle_pkg::*;
(
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   accept_in,
    input  logic   first_in,
    input  coord_t x_in,
    input  coord_t y_in,
    input  coord_t screen_min_x,
    input  coord_t screen_max_x,
    input  coord_t screen_min_y,
    input  coord_t screen_max_y,
    output logic   overlap_out
);

    coord_t min_x_q, max_x_q, min_y_q, max_y_q;
    coord_t min_x_d, max_x_d, min_y_d, max_y_d;

    always_comb begin
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        if (accept_in) begin
            if (first_in) begin
                min_x_d = x_in;
                max_x_d = x_in;
                min_y_d = y_in;
                max_y_d = y_in;
            end else begin
                min_x_d = coord_min(min_x_q, x_in);
                max_x_d = coord_max(max_x_q, x_in);
                min_y_d = coord_min(min_y_q, y_in);
                max_y_d = coord_max(max_y_q, y_in);
            end
        end
    end

    // Test the box including any vertex accepted this cycle, so a close that
    // coincides with the last vertex sees the complete box.
    assign overlap_out = (max_x_d >= screen_min_x) && (min_x_d <= screen_max_x) &&
                         (max_y_d >= screen_min_y) && (min_y_d <= screen_max_y);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
        end else begin
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/obstacle_screen_culler.sv
// +----------------------------------------------------------------------------+
// | obstacle_screen_culler: keeps on-screen obstacles, double-buffered output.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module obstacle_screen_culler
    import obstacle_pkg::*;
#(
    parameter int WORLD_BITS              = COORD_BITS,
    parameter int MAX_NUM_VERTICES        = 8,
    parameter int MAX_OBSTACLES_ON_SCREEN = 2,
    localparam int C_OBS_IDX_W = (MAX_OBSTACLES_ON_SCREEN > 1) ? $clog2(MAX_OBSTACLES_ON_SCREEN) : 1,
    localparam int C_VTX_IDX_W = $clog2(MAX_NUM_VERTICES),
    localparam int C_VTX_CNT_W = C_VTX_IDX_W + 1,
    localparam int C_OBS_CNT_W = $clog2(MAX_OBSTACLES_ON_SCREEN) + 1
)(
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic signed [WORLD_BITS-1:0]  x_in,
    input  logic signed [WORLD_BITS-1:0]  y_in,
    input  logic signed [WORLD_BITS-1:0]  screen_min_x,
    input  logic signed [WORLD_BITS-1:0]  screen_max_x,
    input  logic signed [WORLD_BITS-1:0]  screen_min_y,
    input  logic signed [WORLD_BITS-1:0]  screen_max_y,
    input  logic                          done_in,
    input  logic [C_OBS_IDX_W-1:0]        rd_obstacle_in,
    input  logic [C_VTX_IDX_W-1:0]        rd_vertex_in,
    output logic signed [WORLD_BITS-1:0]  rd_x_out,
    output logic signed [WORLD_BITS-1:0]  rd_y_out,
    output logic [C_VTX_CNT_W-1:0]        rd_num_vertices_out,
    output logic [C_OBS_CNT_W-1:0]        num_obstacles_out,
    output logic                          overflow_out,
    output logic                          frame_valid_out
);

    vertex_t                  vtx_mem_q [2][MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
    logic [C_VTX_CNT_W-1:0]   cnt_mem_q [2][MAX_OBSTACLES_ON_SCREEN];

    logic                     bank_q, bank_d;
    logic [C_OBS_CNT_W-1:0]   count_q, count_d;
    logic [C_VTX_CNT_W-1:0]   vidx_q, vidx_d;
    logic                     in_obs_q, in_obs_d;
    logic                     wovf_q, wovf_d;
    logic [C_OBS_CNT_W-1:0]   num_obs_q, num_obs_d;
    logic                     ovf_q, ovf_d;
    logic                     frame_valid_q, frame_valid_d;

    logic                     w_wr_bank;
    logic                     w_vtx_room;
    logic                     w_slot_room;
    logic                     w_close;
    logic                     w_overlap;
    logic                     w_vtx_we;
    logic                     w_cnt_we;
    logic [C_VTX_CNT_W-1:0]   w_close_cnt;

    assign w_wr_bank   = ~bank_q;
    assign w_vtx_room  = (vidx_q < C_VTX_CNT_W'(MAX_NUM_VERTICES));
    assign w_slot_room = (count_q < C_OBS_CNT_W'(MAX_OBSTACLES_ON_SCREEN));
    assign w_close     = (in_obs_q && !valid_in) || (done_in && (in_obs_q || valid_in));
    assign w_vtx_we    = valid_in && w_vtx_room && w_slot_room;
    assign w_close_cnt = (valid_in && w_vtx_room) ? vidx_q + 1'b1 : vidx_q;

    bbox_accumulator u_bbox (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .accept_in    (valid_in),
        .first_in     (valid_in && !in_obs_q),
        .x_in         (x_in),
        .y_in         (y_in),
        .screen_min_x (screen_min_x),
        .screen_max_x (screen_max_x),
        .screen_min_y (screen_min_y),
        .screen_max_y (screen_max_y),
        .overlap_out  (w_overlap)
    );

    always_comb begin
        bank_d        = bank_q;
        count_d       = count_q;
        vidx_d        = vidx_q;
        in_obs_d      = in_obs_q;
        wovf_d        = wovf_q;
        num_obs_d     = num_obs_q;
        ovf_d         = ovf_q;
        frame_valid_d = 1'b0;
        w_cnt_we      = 1'b0;

        if (valid_in) begin
            in_obs_d = 1'b1;
            if (w_vtx_room) vidx_d = vidx_q + 1'b1;
            else            wovf_d = 1'b1;
        end

        if (w_close) begin
            in_obs_d = 1'b0;
            vidx_d   = '0;
            if (w_overlap) begin
                if (w_slot_room) begin
                    w_cnt_we = 1'b1;
                    count_d  = count_q + 1'b1;
                end else begin
                    wovf_d = 1'b1;
                end
            end
        end

        // Publish sees the working state after this cycle's accept and close.
        if (done_in) begin
            bank_d        = ~bank_q;
            num_obs_d     = count_d;
            ovf_d         = wovf_d;
            count_d       = '0;
            wovf_d        = 1'b0;
            vidx_d        = '0;
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bank_q        <= 1'b0;
            count_q       <= '0;
            vidx_q        <= '0;
            in_obs_q      <= 1'b0;
            wovf_q        <= 1'b0;
            num_obs_q     <= '0;
            ovf_q         <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            count_q       <= count_d;
            vidx_q        <= vidx_d;
            in_obs_q      <= in_obs_d;
            wovf_q        <= wovf_d;
            num_obs_q     <= num_obs_d;
            ovf_q         <= ovf_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_vtx_we)
            vtx_mem_q[w_wr_bank][count_q[C_OBS_IDX_W-1:0]][vidx_q[C_VTX_IDX_W-1:0]] <= '{x: x_in, y: y_in};
        if (w_cnt_we)
            cnt_mem_q[w_wr_bank][count_q[C_OBS_IDX_W-1:0]] <= w_close_cnt;
    end

    // Indices past the published obstacle or vertex count read back as zero.
    always_comb begin
        rd_num_vertices_out = '0;
        rd_x_out            = '0;
        rd_y_out            = '0;
        if (C_OBS_CNT_W'(rd_obstacle_in) < num_obs_q) begin
            rd_num_vertices_out = cnt_mem_q[bank_q][rd_obstacle_in];
            if ({1'b0, rd_vertex_in} < rd_num_vertices_out) begin
                rd_x_out = vtx_mem_q[bank_q][rd_obstacle_in][rd_vertex_in].x;
                rd_y_out = vtx_mem_q[bank_q][rd_obstacle_in][rd_vertex_in].y;
            end
        end
    end

    assign num_obstacles_out = num_obs_q;
    assign overflow_out      = ovf_q;
    assign frame_valid_out   = frame_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_screen_culler.sv
// +----------------------------------------------------------------------------+
// | tb_obstacle_screen_culler: frame-level reference model bench for the culler.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_obstacle_screen_culler;

    localparam int MAXV = 8;
    localparam int MAXO = 2;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               valid_in = 1'b0;
    logic               done_in = 1'b0;
    logic signed [31:0] x_in = '0;
    logic signed [31:0] y_in = '0;
    logic signed [31:0] scr_min_x = 0;
    logic signed [31:0] scr_max_x = 100;
    logic signed [31:0] scr_min_y = 0;
    logic signed [31:0] scr_max_y = 100;
    logic [0:0]         rd_obstacle_in = '0;
    logic [2:0]         rd_vertex_in = '0;
    logic signed [31:0] rd_x_out;
    logic signed [31:0] rd_y_out;
    logic [3:0]         rd_num_vertices_out;
    logic [1:0]         num_obstacles_out;
    logic               overflow_out;
    logic               frame_valid_out;

    always #5 clk_in = ~clk_in;

    obstacle_screen_culler #(
        .WORLD_BITS              (32),
        .MAX_NUM_VERTICES        (MAXV),
        .MAX_OBSTACLES_ON_SCREEN (MAXO)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .valid_in            (valid_in),
        .x_in                (x_in),
        .y_in                (y_in),
        .screen_min_x        (scr_min_x),
        .screen_max_x        (scr_max_x),
        .screen_min_y        (scr_min_y),
        .screen_max_y        (scr_max_y),
        .done_in             (done_in),
        .rd_obstacle_in      (rd_obstacle_in),
        .rd_vertex_in        (rd_vertex_in),
        .rd_x_out            (rd_x_out),
        .rd_y_out            (rd_y_out),
        .rd_num_vertices_out (rd_num_vertices_out),
        .num_obstacles_out   (num_obstacles_out),
        .overflow_out        (overflow_out),
        .frame_valid_out     (frame_valid_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame under construction: flat vertex lists plus per-obstacle lengths.
    int fx[$];
    int fy[$];
    int flen[$];
    int cur_len = 0;

    // Expected published frame.
    int exp_n;
    int exp_ovf;
    int exp_nv [MAXO];
    int exp_vx [MAXO][MAXV];
    int exp_vy [MAXO][MAXV];

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
        int exp_n;
    } edge_vec_t;

    edge_vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic new_frame();
        fx.delete();
        fy.delete();
        flen.delete();
        cur_len = 0;
    endtask

    task automatic add_v(input int x, input int y);
        fx.push_back(x);
        fy.push_back(y);
        cur_len++;
    endtask

    task automatic end_obs();
        flen.push_back(cur_len);
        cur_len = 0;
    endtask

    // Whole-frame reference: box over every vertex, keep test, first-come slots.
    task automatic model_frame();
        int base, mnx, mxx, mny, mxy, keep, stored;
        base    = 0;
        exp_n   = 0;
        exp_ovf = 0;
        for (int o = 0; o < MAXO; o++) exp_nv[o] = 0;
        for (int o = 0; o < flen.size(); o++) begin
            mnx = fx[base]; mxx = fx[base]; mny = fy[base]; mxy = fy[base];
            for (int k = 1; k < flen[o]; k++) begin
                if (fx[base+k] < mnx) mnx = fx[base+k];
                if (fx[base+k] > mxx) mxx = fx[base+k];
                if (fy[base+k] < mny) mny = fy[base+k];
                if (fy[base+k] > mxy) mxy = fy[base+k];
            end
            keep = (mxx >= scr_min_x) && (mnx <= scr_max_x) &&
                   (mxy >= scr_min_y) && (mny <= scr_max_y);
            if (flen[o] > MAXV) exp_ovf = 1;
            if (keep) begin
                if (exp_n < MAXO) begin
                    stored = (flen[o] > MAXV) ? MAXV : flen[o];
                    exp_nv[exp_n] = stored;
                    for (int k = 0; k < stored; k++) begin
                        exp_vx[exp_n][k] = fx[base+k];
                        exp_vy[exp_n][k] = fy[base+k];
                    end
                    exp_n++;
                end else begin
                    exp_ovf = 1;
                end
            end
            base += flen[o];
        end
    endtask

    task automatic run_frame(input bit done_last);
        int base, nobs_f, ev;
        model_frame();
        base   = 0;
        nobs_f = flen.size();
        for (int o = 0; o < nobs_f; o++) begin
            for (int k = 0; k < flen[o]; k++) begin
                valid_in = 1'b1;
                x_in     = fx[base+k];
                y_in     = fy[base+k];
                done_in  = done_last && (o == nobs_f - 1) && (k == flen[o] - 1);
                tick();
            end
            base += flen[o];
            valid_in = 1'b0;
            done_in  = 1'b0;
            if (!(done_last && o == nobs_f - 1)) repeat (1 + $urandom_range(1)) tick();
        end
        if (!done_last || nobs_f == 0) begin
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
        end
        check("frame_valid_pulse", int'(frame_valid_out), 1);
        check("num_obstacles", int'(num_obstacles_out), exp_n);
        check("overflow", int'(overflow_out), exp_ovf);
        for (int o = 0; o < MAXO; o++) begin
            rd_obstacle_in = 1'(o);
            rd_vertex_in   = '0;
            #1;
            check($sformatf("rd_num_vertices[%0d]", o), int'(rd_num_vertices_out),
                  (o < exp_n) ? exp_nv[o] : 0);
            for (int v = 0; v < MAXV; v++) begin
                rd_vertex_in = 3'(v);
                #1;
                ev = (o < exp_n) && (v < exp_nv[o]);
                check($sformatf("rd_x[%0d][%0d]", o, v), rd_x_out, ev ? exp_vx[o][v] : 0);
                check($sformatf("rd_y[%0d][%0d]", o, v), rd_y_out, ev ? exp_vy[o][v] : 0);
            end
        end
        tick();
        check("frame_valid_one_cycle", int'(frame_valid_out), 0);
    endtask

    task automatic spot(input int o, input int v, input int ex, input int ey);
        rd_obstacle_in = 1'(o);
        rd_vertex_in   = 3'(v);
        #1;
        check($sformatf("spot_x[%0d][%0d]", o, v), rd_x_out, ex);
        check($sformatf("spot_y[%0d][%0d]", o, v), rd_y_out, ey);
    endtask

    task automatic spot_nv(input int o, input int exp);
        rd_obstacle_in = 1'(o);
        rd_vertex_in   = '0;
        #1;
        check($sformatf("spot_nv[%0d]", o), int'(rd_num_vertices_out), exp);
    endtask

    initial begin
        tbl[0] = '{-50, -50, 0, 0, 1};
        tbl[1] = '{101, 10, 150, 20, 0};
        tbl[2] = '{100, 100, 200, 200, 1};
        tbl[3] = '{-20, 10, -1, 20, 0};
        tbl[4] = '{10, 101, 20, 300, 0};
        tbl[5] = '{10, -30, 20, -1, 0};
        tbl[6] = '{-1000, -1000, 1000, 1000, 1};
        tbl[7] = '{50, 50, 50, 50, 1};
        tbl[8] = '{32'sh80000000, 0, 32'sh80000001, 5, 0};
        tbl[9] = '{32'sh80000000, 32'sh80000000, 32'sh7fffffff, 32'sh7fffffff, 1};

        // Reset state
        @(posedge clk_in);
        #1;
        check("reset_num_obstacles", int'(num_obstacles_out), 0);
        check("reset_overflow", int'(overflow_out), 0);
        check("reset_frame_valid", int'(frame_valid_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();

        // done_in alone publishes an empty frame
        new_frame();
        run_frame(1'b0);
        check("empty_frame_count", int'(num_obstacles_out), 0);

        // Frame 1
        new_frame();
        add_v(150, 50); add_v(50, -1); add_v(20, 20); add_v(300, 300); end_obs();
        for (int k = 2; k <= 6; k++) add_v(k * 100, k * 100);
        end_obs();
        run_frame(1'b0);
        check("f1_num_obstacles", int'(num_obstacles_out), 1);
        check("f1_overflow", int'(overflow_out), 0);
        spot_nv(0, 4);
        spot(0, 1, 50, -1);

        // Frame 2: third kept obstacle has no slot
        new_frame();
        add_v(20, 200); add_v(500, 500); add_v(30, 30); end_obs();
        add_v(40, 40); add_v(50, 50); add_v(60, 60); end_obs();
        add_v(20, 20); add_v(500, 500); add_v(300, 30); end_obs();
        run_frame(1'b0);
        check("f2_num_obstacles", int'(num_obstacles_out), 2);
        check("f2_overflow", int'(overflow_out), 1);
        spot(1, 2, 60, 60);

        // Reset mid-frame clears outputs at once and discards the partial obstacle
        valid_in = 1'b1; x_in = 10; y_in = 10;
        tick();
        x_in = 20; y_in = 20;
        tick();
        #2;
        rst_in = 1'b1;
        #1;
        check("midreset_num_obstacles", int'(num_obstacles_out), 0);
        check("midreset_overflow", int'(overflow_out), 0);
        check("midreset_frame_valid", int'(frame_valid_out), 0);
        valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        new_frame();
        run_frame(1'b0);

        // Ten vertices inside: truncated to eight
        new_frame();
        for (int k = 0; k < 10; k++) add_v(10 + k, 10 + k);
        end_obs();
        run_frame(1'b0);
        spot_nv(0, 8);
        check("trunc_overflow", int'(overflow_out), 1);
        spot(0, 7, 17, 17);

        // done_in together with the final vertex
        new_frame();
        add_v(10, 10); add_v(20, 20); add_v(30, 30); end_obs();
        run_frame(1'b1);
        check("done_with_vertex_count", int'(num_obstacles_out), 1);
        spot_nv(0, 3);
        spot(0, 2, 30, 30);

        // Boundary table, single two-vertex obstacle per frame
        for (int i = 0; i < 10; i++) begin
            new_frame();
            add_v(tbl[i].x0, tbl[i].y0);
            add_v(tbl[i].x1, tbl[i].y1);
            end_obs();
            run_frame(1'b0);
            check($sformatf("edge_tbl[%0d]", i), int'(num_obstacles_out), tbl[i].exp_n);
        end

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(1) == 0) begin
                scr_min_x = 0; scr_max_x = 100; scr_min_y = 0; scr_max_y = 100;
            end else begin
                scr_min_x = int'($urandom_range(200)) - 100;
                scr_max_x = scr_min_x + int'($urandom_range(200));
                scr_min_y = int'($urandom_range(200)) - 100;
                scr_max_y = scr_min_y + int'($urandom_range(200));
            end
            new_frame();
            for (int o = 0, n = int'($urandom_range(3)); o < n; o++) begin
                for (int k = 0, l = 1 + int'($urandom_range(9)); k < l; k++)
                    add_v(int'($urandom_range(400)) - 150, int'($urandom_range(400)) - 150);
                end_obs();
            end
            run_frame(1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
